// File: rtl/prf_pkg.sv
// Shared defaults, address type and FSM state encoding for the physical register file.
package prf_pkg;

  localparam int PRF_DATA_WIDTH = 32;
  localparam int PRF_PHYS_REGS  = 64;
  localparam int PRF_ADDR_W     = $clog2(PRF_PHYS_REGS);

  typedef logic [PRF_ADDR_W-1:0] phys_addr_t;

  typedef enum logic {
    PRF_CLEAR = 1'b0,
    PRF_RUN   = 1'b1
  } prf_state_e;

endpackage

// File: rtl/prf_busy_table.sv
// Busy scoreboard: per-register flag set by rename allocation and cleared by
// write-back or recovery flush. Priority per bit: alloc > write > flush > hold.
module prf_busy_table
  import prf_pkg::*;
#(
  parameter int PHYS_REGS   = PRF_PHYS_REGS,
  parameter int WRITE_PORTS = 2,
  parameter int ADDR_W      = $clog2(PHYS_REGS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_run,
  input  logic                          i_alloc_valid,
  input  logic [ADDR_W-1:0]             i_alloc_addr,
  input  logic [WRITE_PORTS-1:0]        i_wr_acc,
  input  logic [WRITE_PORTS*ADDR_W-1:0] i_wr_addr,
  input  logic                          i_flush_valid,
  input  logic [PHYS_REGS-1:0]          i_flush_mask,
  output logic [PHYS_REGS-1:0]          o_busy
);

  logic [PHYS_REGS-1:0] r_busy;
  logic [PHYS_REGS-1:0] w_busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < PHYS_REGS; gi++) begin : g_bit
      logic w_set;
      logic w_wr_clr;
      logic w_fl_clr;

      always_comb begin
        w_wr_clr = 1'b0;
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (i_wr_acc[p] && (i_wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(gi)))
            w_wr_clr = 1'b1;
        end
      end

      assign w_set    = i_run & i_alloc_valid & (i_alloc_addr == ADDR_W'(gi));
      assign w_fl_clr = i_run & i_flush_valid & i_flush_mask[gi];

      // p0 is the hardwired zero register and can never be outstanding.
      assign w_busy_next[gi] = (gi == 0)             ? 1'b0 :
                               w_set                 ? 1'b1 :
                               (w_wr_clr | w_fl_clr) ? 1'b0 :
                                                       r_busy[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/phys_reg_file.sv
// Physical register file with async read ports, write-back ports, busy scoreboard
// and a post-reset clear sweep. Define PRF_BYPASS_EN for same-cycle write-to-read forwarding.
module phys_reg_file
  import prf_pkg::*;
#(
  parameter int   DATA_WIDTH  = PRF_DATA_WIDTH,
  parameter int   PHYS_REGS   = PRF_PHYS_REGS,
  parameter int   READ_PORTS  = 4,
  parameter int   WRITE_PORTS = 2,
  localparam int  ADDR_W      = $clog2(PHYS_REGS)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              alloc_valid,
  input  logic [ADDR_W-1:0]                 alloc_addr,
  input  logic [READ_PORTS-1:0]             rd_en,
  input  logic [READ_PORTS*ADDR_W-1:0]      rd_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  rd_data,
  output logic [READ_PORTS-1:0]             rd_ready,
  input  logic [WRITE_PORTS-1:0]            wr_en,
  input  logic [WRITE_PORTS*ADDR_W-1:0]     wr_addr,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                              flush_valid,
  input  logic [PHYS_REGS-1:0]              flush_mask,
  output logic [PHYS_REGS-1:0]              busy,
  output logic [WRITE_PORTS-1:0]            commit_rw,
  output logic                              init_done
);

  prf_state_e             r_state;
  prf_state_e             w_state_next;
  logic [ADDR_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0]  r_regs [PHYS_REGS];
  logic [WRITE_PORTS-1:0] w_wr_acc;
  logic [WRITE_PORTS-1:0] r_commit;
  logic                   w_run;
  logic                   w_sweep_last;

  assign w_run        = (r_state == PRF_RUN);
  assign w_sweep_last = (r_idx == ADDR_W'(PHYS_REGS - 1));
  assign init_done    = w_run;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PRF_CLEAR: if (w_sweep_last) w_state_next = PRF_RUN;
      PRF_RUN:   w_state_next = PRF_RUN;
      default:   w_state_next = PRF_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PRF_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      if (!w_run) r_idx <= r_idx + ADDR_W'(1);
    end
  end

  // Writes to p0 are discarded entirely: no data, no busy clear, no commit pulse.
  genvar gi;
  generate
    for (gi = 0; gi < WRITE_PORTS; gi++) begin : g_wacc
      assign w_wr_acc[gi] = w_run & wr_en[gi] & (wr_addr[gi*ADDR_W +: ADDR_W] != '0);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit <= '0;
    end else begin
      r_commit <= w_wr_acc;
    end
  end

  assign commit_rw = r_commit;

  // No reset on the array so it can map onto RAM; the sweep provides the zeroing.
  // Later ports overwrite earlier ones, so the highest-indexed port wins a collision.
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_regs[r_idx] <= '0;
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (w_wr_acc[p])
          r_regs[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  generate
    for (gi = 0; gi < READ_PORTS; gi++) begin : g_rd
      logic [ADDR_W-1:0]     w_addr;
      logic [DATA_WIDTH-1:0] w_data;
      logic                  w_hit;

      assign w_addr = rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        w_hit  = 1'b0;
        w_data = r_regs[w_addr];
`ifdef PRF_BYPASS_EN
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (w_wr_acc[p] && (wr_addr[p*ADDR_W +: ADDR_W] == w_addr)) begin
            w_hit  = 1'b1;
            w_data = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
`endif
      end

      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        (w_run && rd_en[gi] && (w_addr != '0)) ? w_data : '0;
      assign rd_ready[gi] = w_run & rd_en[gi] & (~busy[w_addr] | w_hit);
    end
  endgenerate

  prf_busy_table #(
    .PHYS_REGS   (PHYS_REGS),
    .WRITE_PORTS (WRITE_PORTS),
    .ADDR_W      (ADDR_W)
  ) u_busy (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_run         (w_run),
    .i_alloc_valid (alloc_valid),
    .i_alloc_addr  (alloc_addr),
    .i_wr_acc      (w_wr_acc),
    .i_wr_addr     (wr_addr),
    .i_flush_valid (flush_valid),
    .i_flush_mask  (flush_mask),
    .o_busy        (busy)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        for (int q = p + 1; q < WRITE_PORTS; q++) begin
          assert (!(w_wr_acc[p] && w_wr_acc[q] &&
                    (wr_addr[p*ADDR_W +: ADDR_W] == wr_addr[q*ADDR_W +: ADDR_W])));
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_phys_reg_file.sv
// Directed bench for phys_reg_file: sweep, alloc/write path, bypass, priority, flush, p0, reset.
module tb_phys_reg_file;
  import prf_pkg::*;

  localparam int DW = 32;
  localparam int NR = 64;
  localparam int RP = 4;
  localparam int WP = 2;
  localparam int AW = 6;

  logic             clk;
  logic             rst_n;
  logic             alloc_valid;
  logic [AW-1:0]    alloc_addr;
  logic [RP-1:0]    rd_en;
  logic [RP*AW-1:0] rd_addr;
  logic [RP*DW-1:0] rd_data;
  logic [RP-1:0]    rd_ready;
  logic [WP-1:0]    wr_en;
  logic [WP*AW-1:0] wr_addr;
  logic [WP*DW-1:0] wr_data;
  logic             flush_valid;
  logic [NR-1:0]    flush_mask;
  logic [NR-1:0]    busy;
  logic [WP-1:0]    commit_rw;
  logic             init_done;

  int n_cmp = 0;
  int n_err = 0;

  phys_reg_file dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_valid (alloc_valid),
    .alloc_addr  (alloc_addr),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_ready    (rd_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .flush_valid (flush_valid),
    .flush_mask  (flush_mask),
    .busy        (busy),
    .commit_rw   (commit_rw),
    .init_done   (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    alloc_addr  = '0;
    wr_en       = '0;
    wr_addr     = '0;
    wr_data     = '0;
    flush_valid = 1'b0;
    flush_mask  = '0;
  endtask

  task automatic set_rd(input int port, input int a);
    logic [AW-1:0] a6;
    a6 = AW'(a);
    rd_en[port] = 1'b1;
    rd_addr[port*AW +: AW] = a6;
  endtask

  task automatic set_wr(input int port, input int a, input logic [DW-1:0] d);
    logic [AW-1:0] a6;
    a6 = AW'(a);
    wr_en[port] = 1'b1;
    wr_addr[port*AW +: AW] = a6;
    wr_data[port*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rdd(input int port);
    return rd_data[port*DW +: DW];
  endfunction

  initial begin
    phys_addr_t a_tmp;
    rst_n = 1'b0;
    rd_en = '0;
    rd_addr = '0;
    idle();
    #1;
    check("rst_busy", busy, 64'h0);
    check("rst_commit", 64'(commit_rw), 64'h0);
    check("rst_init", 64'(init_done), 64'h0);
    @(negedge clk);
    @(negedge clk);

    // Reset sweep with traffic that must be ignored
    rst_n = 1'b1;
    set_wr(0, 5, 32'h0000AAAA);
    alloc_valid = 1'b1;
    alloc_addr  = 6'd6;
    set_rd(0, 5);
    for (int k = 1; k <= 64; k++) begin
      step();
      check($sformatf("sweep_init%0d", k), 64'(init_done), (k == 64) ? 64'h1 : 64'h0);
      if (k < 64) begin
        check($sformatf("sweep_rdy%0d", k), 64'(rd_ready[0]), 64'h0);
        check($sformatf("sweep_cmt%0d", k), 64'(commit_rw), 64'h0);
      end
      if (k == 63) idle();
    end
    #1;
    check("sweep_busy", busy, 64'h0);
    check("p5_data", 64'(rdd(0)), 64'h0);
    check("p5_ready", 64'(rd_ready[0]), 64'h1);

    // Basic path: alloc p7 at t, write at t+3
    alloc_valid = 1'b1;
    alloc_addr  = 6'd7;
    step();
    idle();
    check("t1_busy7", 64'(busy[7]), 64'h1);
    step();
    check("t2_busy7", 64'(busy[7]), 64'h1);
    step();
    check("t3_busy7", 64'(busy[7]), 64'h1);
    set_wr(0, 7, 32'hDEADBEEF);
    set_rd(0, 7);
    #1;
`ifdef PRF_BYPASS_EN
    check("t3_rd7", 64'(rdd(0)), 64'hDEADBEEF);
    check("t3_rdy7", 64'(rd_ready[0]), 64'h1);
`else
    check("t3_rd7", 64'(rdd(0)), 64'h0);
    check("t3_rdy7", 64'(rd_ready[0]), 64'h0);
`endif
    step();
    idle();
    #1;
    check("t4_busy7", 64'(busy[7]), 64'h0);
    check("t4_commit", 64'(commit_rw), 64'h1);
    check("t4_rd7", 64'(rdd(0)), 64'hDEADBEEF);
    check("t4_rdy7", 64'(rd_ready[0]), 64'h1);
    step();
    check("t5_commit", 64'(commit_rw), 64'h0);

    // Same-cycle write/read of p9 through write port 1, read port 2
    alloc_valid = 1'b1;
    alloc_addr  = 6'd9;
    step();
    idle();
    check("p9_busy", 64'(busy[9]), 64'h1);
    set_wr(1, 9, 32'h00001234);
    set_rd(2, 9);
    #1;
`ifdef PRF_BYPASS_EN
    check("byp_rd9", 64'(rdd(2)), 64'h1234);
    check("byp_rdy9", 64'(rd_ready[2]), 64'h1);
`else
    check("byp_rd9", 64'(rdd(2)), 64'h0);
    check("byp_rdy9", 64'(rd_ready[2]), 64'h0);
`endif
    step();
    idle();
    #1;
    check("p9_rd_after", 64'(rdd(2)), 64'h1234);
    check("p9_rdy_after", 64'(rd_ready[2]), 64'h1);
    check("p9_commit", 64'(commit_rw), 64'h2);

    // Priority: alloc beats write, alloc beats flush
    alloc_valid = 1'b1;
    alloc_addr  = 6'd12;
    set_wr(0, 12, 32'h00005555);
    step();
    idle();
    set_rd(1, 12);
    #1;
    check("pri_busy12", 64'(busy[12]), 64'h1);
    check("pri_commit", 64'(commit_rw), 64'h1);
    check("pri_rd12", 64'(rdd(1)), 64'h5555);
    check("pri_rdy12", 64'(rd_ready[1]), 64'h0);
    alloc_valid = 1'b1;
    alloc_addr  = 6'd12;
    flush_valid = 1'b1;
    flush_mask  = 64'h1000;
    step();
    idle();
    check("pri_fl_busy12", 64'(busy[12]), 64'h1);
    flush_valid = 1'b1;
    flush_mask  = 64'h1000;
    step();
    idle();
    check("fl_busy12", 64'(busy[12]), 64'h0);

    // Flush of a subset of outstanding registers
    for (int r = 3; r <= 5; r++) begin
      alloc_valid = 1'b1;
      alloc_addr  = AW'(r);
      step();
    end
    idle();
    check("fl_pre_busy", busy, 64'h38);
    flush_valid = 1'b1;
    flush_mask  = 64'h28;
    step();
    idle();
    check("fl_post_busy", busy, 64'h10);

    // p0: writes dropped, alloc ignored, reads zero
    a_tmp = '0;
    set_wr(0, 0, 32'h0000FFFF);
    alloc_valid = 1'b1;
    alloc_addr  = a_tmp;
    set_rd(3, 0);
    #1;
    check("p0_rd_same", 64'(rdd(3)), 64'h0);
    check("p0_rdy_same", 64'(rd_ready[3]), 64'h1);
    step();
    idle();
    #1;
    check("p0_commit", 64'(commit_rw), 64'h0);
    check("p0_busy", busy, 64'h10);
    check("p0_rd_after", 64'(rdd(3)), 64'h0);

    // Mid-run reset: state clears immediately and the sweep restarts
    rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 64'h0);
    check("mr_init", 64'(init_done), 64'h0);
    check("mr_rdy", 64'(rd_ready), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = '0;
    set_rd(0, 7);
    for (int k = 1; k <= 64; k++) begin
      step();
      if (k >= 63)
        check($sformatf("resweep_init%0d", k), 64'(init_done), (k == 64) ? 64'h1 : 64'h0);
    end
    #1;
    check("resweep_rd7", 64'(rdd(0)), 64'h0);
    check("resweep_rdy7", 64'(rd_ready[0]), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phys_reg_file.md
# phys_reg_file

Parametrised physical register file for the register-renaming out-of-order core. It sits between the rename stage and the issue/execute stages. It holds PHYS_REGS data words with READ_PORTS asynchronous read ports and WRITE_PORTS synchronous write-back ports. It also keeps a busy (not-yet-written) scoreboard that rename sets on allocation, write-back clears, and branch recovery can flush. After reset it runs a sequential clear sweep so the array can map to RAM without a per-word reset.

## Interface
Parameters:
- DATA_WIDTH, 32, data word width
- PHYS_REGS, 64, physical register count (power of two, ≥ 8)
- READ_PORTS, 4, asynchronous read ports
- WRITE_PORTS, 2, write-back ports
- ADDR_W, $clog2(PHYS_REGS), derived, not overridden

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alloc_valid  in  1  rename allocates a destination this cycle
- alloc_addr  in  ADDR_W  physical register being allocated
- rd_en  in  READ_PORTS  per-port read enable
- rd_addr  in  READ_PORTS×ADDR_W  read addresses
- rd_data  out  READ_PORTS×DATA_WIDTH  read data; '0 when disabled
- rd_ready  out  READ_PORTS  addressed register is not busy
- wr_en  in  WRITE_PORTS  write-back valid
- wr_addr  in  WRITE_PORTS×ADDR_W  write-back addresses
- wr_data  in  WRITE_PORTS×DATA_WIDTH  write-back data
- flush_valid  in  1  recovery: clear busy bits in flush_mask
- flush_mask  in  PHYS_REGS  registers whose producers were squashed
- busy  out  PHYS_REGS  scoreboard, registered
- commit_rw  out  WRITE_PORTS  registered pulse, one per accepted write
- init_done  out  1  clear sweep complete

## Operation
- FSM with two states. CLEAR: counter idx writes '0 to regs[idx] each cycle, from 0 to PHYS_REGS-1, then goes to RUN. RUN is terminal until the next reset.
- In CLEAR, the block ignores alloc, wr_en and flush. rd_data = '0, rd_ready = 0, commit_rw = 0.
- Register p0 is hardwired to zero. Writes to p0 are dropped and do not pulse commit_rw. p0 is never busy, and alloc of p0 is ignored.
- A read returns regs[rd_addr] when rd_en = 1, otherwise '0. rd_ready = rd_en & ~busy[rd_addr].
- A write stores wr_data, clears busy[wr_addr] on the next edge, and sets commit_rw[port] for one cycle.
- Two ports writing the same address in the same cycle: the highest-indexed port's data wins. The simulation assertion fires.
- Busy next-state priority, per bit: alloc (set) > write (clear) > flush (clear) > hold. The same-cycle write still updates data.

## Timing
- Reset values: busy = '0, commit_rw = '0, init_done = 0, FSM = CLEAR, idx = 0.
- init_done rises on the PHYS_REGS-th rising edge after rst_n deasserts, and stays high.
- Reads are combinational, with zero-cycle latency.
- A write is visible to reads on the cycle after wr_en (without the bypass). The busy clear and the commit_rw pulse appear in that same cycle.
- An alloc sets the busy bit one cycle after alloc_valid. A flush takes effect one cycle after flush_valid.
- rst_n asserted mid-sweep or mid-operation: the FSM, idx and scoreboard reset immediately, and the sweep restarts from 0.

## Configuration
- PRF_BYPASS_EN defined: write-to-read forwarding in RUN. A read whose address matches an active wr_addr in the same cycle returns that wr_data; the highest port wins. Its rd_ready is 1 even though busy is still set. p0 is never bypassed.
- Not defined: no forwarding. Same-cycle reads return the old array contents and rd_ready reflects the registered busy bit.

## Structure
- Package prf_pkg holds DATA_WIDTH/PHYS_REGS defaults, the phys_addr_t typedef and the FSM state enum prf_state_e (PRF_CLEAR, PRF_RUN).
- Sub-module prf_busy_table holds the scoreboard with alloc/write/flush priority logic and outputs busy. It is instantiated once.
- The data array, read muxes, bypass and FSM live in phys_reg_file.

## Test plan
- Reset sweep: release rst_n, hold wr_en = 1 to p5 → no write; init_done rises exactly at cycle 64; reading p5 gives 0.
- Basic path: alloc p7 at cycle t, then at t+3 write p7 = 32'hDEADBEEF → busy[7] = 1 from t+1 to t+3 and 0 at t+4; commit_rw[0] pulses at t+4; the read returns DEADBEEF at t+4.
- Bypass: same-cycle write and read of p9 = 32'h1234 → with PRF_BYPASS_EN, rd_data = 1234 and rd_ready = 1 that cycle; without it, the old value (0) is returned and rd_ready = 0.
- Priority: alloc p12 and write p12 in the same cycle → busy[12] = 1 next cycle and the data is updated. Flush mask bit 12 with alloc p12 → busy stays 1.
- Flush: alloc p3, p4, p5, then flush_mask = bits {3,5} → next cycle busy[3] = 0, busy[4] = 1, busy[5] = 0.
- p0 and mid-run reset: write p0 = 32'hFFFF → reads 0 and no commit_rw pulse. Assert rst_n low mid-run → busy = 0 and init_done = 0 immediately, and the sweep restarts.
